// File: rtl/range_tracker_mc.sv
// range_tracker_mc: session-based multi-channel running min/max tracker.
// A session opens on go, folds valid samples per channel, and on finish
// publishes min, max, range and sample count with a one-cycle done strobe.
// Protocol misuse is reported through a sticky error flag and error code.
module range_tracker_mc #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    go,
    input  logic                    finish,
    input  logic                    data_valid,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic [NUM_CH*WIDTH-1:0] min_out,
    output logic [NUM_CH*WIDTH-1:0] max_out,
    output logic [NUM_CH*WIDTH-1:0] range_out,
    output logic [CNT_W-1:0]        sample_count,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              error_code
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READING,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_GO_FINISH  = 2'd1;
    localparam logic [1:0] ERR_NO_SESSION = 2'd2;
    localparam logic [1:0] ERR_ZERO_SAMP  = 2'd3;

    state_t                  state;
    logic [NUM_CH*WIDTH-1:0] cur_min;
    logic [NUM_CH*WIDTH-1:0] cur_max;
    logic [CNT_W-1:0]        cnt;

    logic [NUM_CH*WIDTH-1:0] nxt_min;
    logic [NUM_CH*WIDTH-1:0] nxt_max;
    logic [NUM_CH*WIDTH-1:0] nxt_range;
    logic [CNT_W-1:0]        cnt_inc;
    logic [CNT_W-1:0]        nxt_cnt;

    // a < b under the configured signedness
    function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0)
            return $signed(a) < $signed(b);
        else
            return a < b;
    endfunction

    // Fold the current sample into the running min/max; an empty session
    // (count 0) loads the sample instead of comparing against stale values.
    always_comb begin
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] mn;
        logic [WIDTH-1:0] mx;
        logic [WIDTH:0]   emn;
        logic [WIDTH:0]   emx;
        logic [WIDTH:0]   diff;
        d         = '0;
        mn        = '0;
        mx        = '0;
        emn       = '0;
        emx       = '0;
        diff      = '0;
        nxt_min   = '0;
        nxt_max   = '0;
        nxt_range = '0;
        cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        nxt_cnt   = data_valid ? cnt_inc : cnt;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            d  = data_in[c*WIDTH +: WIDTH];
            mn = cur_min[c*WIDTH +: WIDTH];
            mx = cur_max[c*WIDTH +: WIDTH];
            if (data_valid) begin
                if (cnt == '0 || lt(d, mn)) mn = d;
                if (cnt == '0 || lt(mx, d)) mx = d;
            end
            nxt_min[c*WIDTH +: WIDTH] = mn;
            nxt_max[c*WIDTH +: WIDTH] = mx;
            emn  = {(SIGNED != 0) && mn[WIDTH-1], mn};
            emx  = {(SIGNED != 0) && mx[WIDTH-1], mx};
            diff = emx - emn;
            nxt_range[c*WIDTH +: WIDTH] = diff[WIDTH-1:0];
        end
    end

    // Session FSM with registered outputs; go&finish outranks every other rule,
    // and go alone opens a session from any state (clearing a pending error).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cur_min      <= '0;
            cur_max      <= '0;
            cnt          <= '0;
            min_out      <= '0;
            max_out      <= '0;
            range_out    <= '0;
            sample_count <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            error_code   <= '0;
        end else begin
            done <= 1'b0;
            busy <= 1'b0;
            if (go && finish) begin
                state      <= S_ERROR;
                error      <= 1'b1;
                error_code <= ERR_GO_FINISH;
            end else if (go) begin
                state <= S_READING;
                busy  <= 1'b1;
                if (state == S_ERROR) begin
                    error      <= 1'b0;
                    error_code <= '0;
                end
                if (data_valid) begin
                    cur_min <= data_in;
                    cur_max <= data_in;
                    cnt     <= CNT_W'(1);
                end else begin
                    cnt <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (finish) begin
                            state      <= S_ERROR;
                            error      <= 1'b1;
                            error_code <= ERR_NO_SESSION;
                        end
                    end
                    S_READING: begin
                        cur_min <= nxt_min;
                        cur_max <= nxt_max;
                        cnt     <= nxt_cnt;
                        if (finish) begin
                            if (nxt_cnt == '0) begin
                                state      <= S_ERROR;
                                error      <= 1'b1;
                                error_code <= ERR_ZERO_SAMP;
                            end else begin
                                state        <= S_DONE;
                                min_out      <= nxt_min;
                                max_out      <= nxt_max;
                                range_out    <= nxt_range;
                                sample_count <= nxt_cnt;
                                done         <= 1'b1;
                            end
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (!finish) state <= S_IDLE;
                    end
                    S_ERROR: begin
                        state <= S_ERROR;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_range_tracker_mc.sv
// tb_range_tracker_mc: scoreboard bench driving one unsigned (CNT_W=3) and one
// signed tracker with identical stimulus and checking both every cycle.
module tb_range_tracker_mc;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        go;
    logic        finish;
    logic        data_valid;
    logic [15:0] data_in;

    logic [15:0] a_min, a_max, a_range;
    logic [2:0]  a_cnt;
    logic        a_busy, a_done, a_err;
    logic [1:0]  a_code;
    logic [15:0] b_min, b_max, b_range;
    logic [15:0] b_cnt;
    logic        b_busy, b_done, b_err;
    logic [1:0]  b_code;

    int n_tests = 0;
    int n_fail  = 0;

    range_tracker_mc #(.WIDTH(8), .NUM_CH(2), .SIGNED(0), .CNT_W(3)) u_uns (
        .clock(clock), .reset_n(reset_n), .go(go), .finish(finish),
        .data_valid(data_valid), .data_in(data_in),
        .min_out(a_min), .max_out(a_max), .range_out(a_range),
        .sample_count(a_cnt), .busy(a_busy), .done(a_done),
        .error(a_err), .error_code(a_code)
    );

    range_tracker_mc #(.WIDTH(8), .NUM_CH(2), .SIGNED(1), .CNT_W(16)) u_sgn (
        .clock(clock), .reset_n(reset_n), .go(go), .finish(finish),
        .data_valid(data_valid), .data_in(data_in),
        .min_out(b_min), .max_out(b_max), .range_out(b_range),
        .sample_count(b_cnt), .busy(b_busy), .done(b_done),
        .error(b_err), .error_code(b_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] amin, amax, arng;
        int          acnt;
        logic [15:0] bmin, bmax, brng;
        int          bcnt;
        bit          busy, done, err;
        int          code;
    } exp_t;

    exp_t sbq[$];
    exp_t me;

    // reference model: 0 idle, 1 reading, 2 done, 3 error
    int m_st;
    int um[2], uM[2], sm[2], sM[2];
    int ucnt, scnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic m_reset();
        m_st = 0;
        ucnt = 0;
        scnt = 0;
        for (int c = 0; c < 2; c++) begin
            um[c] = 0; uM[c] = 0; sm[c] = 0; sM[c] = 0;
        end
        me = '{default: 0};
    endtask

    task automatic m_sample(input int d0, input int d1);
        int d[2];
        d[0] = d0 & 255;
        d[1] = d1 & 255;
        for (int c = 0; c < 2; c++) begin
            if (ucnt == 0) begin
                um[c] = d[c]; uM[c] = d[c];
                sm[c] = sx8(d[c]); sM[c] = sx8(d[c]);
            end else begin
                if (d[c] < um[c]) um[c] = d[c];
                if (d[c] > uM[c]) uM[c] = d[c];
                if (sx8(d[c]) < sm[c]) sm[c] = sx8(d[c]);
                if (sx8(d[c]) > sM[c]) sM[c] = sx8(d[c]);
            end
        end
        ucnt = (ucnt < 7) ? ucnt + 1 : 7;
        scnt = (scnt < 65535) ? scnt + 1 : 65535;
    endtask

    task automatic m_open(input bit v, input int d0, input int d1);
        m_st = 1;
        ucnt = 0;
        scnt = 0;
        if (v) m_sample(d0, d1);
    endtask

    task automatic m_step(input bit g, input bit f, input bit v, input int d0, input int d1);
        me.done = 0;
        if (g && f) begin
            m_st = 3; me.err = 1; me.code = 1;
        end else if (g) begin
            if (m_st == 3) begin me.err = 0; me.code = 0; end
            m_open(v, d0, d1);
        end else begin
            case (m_st)
                0: if (f) begin m_st = 3; me.err = 1; me.code = 2; end
                1: begin
                    if (v) m_sample(d0, d1);
                    if (f) begin
                        if (ucnt == 0) begin
                            m_st = 3; me.err = 1; me.code = 3;
                        end else begin
                            m_st = 2;
                            me.done = 1;
                            me.acnt = ucnt;
                            me.bcnt = scnt;
                            for (int c = 0; c < 2; c++) begin
                                me.amin[c*8 +: 8] = 8'(um[c]);
                                me.amax[c*8 +: 8] = 8'(uM[c]);
                                me.arng[c*8 +: 8] = 8'(uM[c] - um[c]);
                                me.bmin[c*8 +: 8] = 8'(sm[c]);
                                me.bmax[c*8 +: 8] = 8'(sM[c]);
                                me.brng[c*8 +: 8] = 8'(sM[c] - sm[c]);
                            end
                        end
                    end
                end
                2: if (!f) m_st = 0;
                default: m_st = 3;
            endcase
        end
        me.busy = (m_st == 1);
    endtask

    task automatic compare();
        exp_t e;
        e = sbq.pop_front();
        check("a_min",   32'(a_min),   32'(e.amin));
        check("a_max",   32'(a_max),   32'(e.amax));
        check("a_range", 32'(a_range), 32'(e.arng));
        check("a_cnt",   32'(a_cnt),   32'(e.acnt));
        check("b_min",   32'(b_min),   32'(e.bmin));
        check("b_max",   32'(b_max),   32'(e.bmax));
        check("b_range", 32'(b_range), 32'(e.brng));
        check("b_cnt",   32'(b_cnt),   32'(e.bcnt));
        check("a_busy",  32'(a_busy),  32'(e.busy));
        check("b_busy",  32'(b_busy),  32'(e.busy));
        check("a_done",  32'(a_done),  32'(e.done));
        check("b_done",  32'(b_done),  32'(e.done));
        check("a_err",   32'(a_err),   32'(e.err));
        check("b_err",   32'(b_err),   32'(e.err));
        check("a_code",  32'(a_code),  32'(e.code));
        check("b_code",  32'(b_code),  32'(e.code));
    endtask

    task automatic step(input bit g, input bit f, input bit v, input int d0, input int d1);
        go         = g;
        finish     = f;
        data_valid = v;
        data_in    = {8'(d1), 8'(d0)};
        m_step(g, f, v, d0, d1);
        sbq.push_back(me);
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_min"},  32'(a_min | a_max | a_range | b_min | b_max | b_range), 32'd0);
        check({tag, "_cnt"},  32'({a_cnt, b_cnt}), 32'd0);
        check({tag, "_flag"}, 32'({a_busy, a_done, a_err, a_code, b_busy, b_done, b_err, b_code}), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        go         = 1'b0;
        finish     = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        m_reset();
        #1;
        check_all_zero("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // basic unsigned session, finish-cycle sample included
        step(1, 0, 1, 10, 200);
        step(0, 0, 1, 3, 250);
        step(0, 0, 1, 40, 100);
        step(0, 1, 1, 7, 150);
        check("t1_min",   32'(a_min),   32'h6403);
        check("t1_max",   32'(a_max),   32'hFA28);
        check("t1_range", 32'(a_range), 32'h9625);
        check("t1_cnt",   32'(a_cnt),   32'd4);
        check("t1_smin",  32'(b_min),   32'h9603);
        step(0, 0, 0, 0, 0);

        // signed extremes
        step(1, 0, 1, 8'h80, 0);
        step(0, 0, 1, 8'h7F, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        check("t2_smin", 32'(b_min[7:0]),   32'h80);
        check("t2_smax", 32'(b_max[7:0]),   32'h7F);
        check("t2_srng", 32'(b_range[7:0]), 32'hFF);
        step(0, 0, 0, 0, 0);

        // go&finish error, sticky code, recovery
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 5, 5);
        step(0, 1, 0, 0, 0);
        check("t3_cnt", 32'(a_cnt), 32'd1);
        step(0, 0, 0, 0, 0);

        // zero-sample session, then bare finish from IDLE
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("t4_code", 32'(a_code), 32'd2);

        // restart mid-session, then finish held in DONE
        step(1, 0, 1, 50, 60);
        step(0, 0, 1, 70, 2);
        step(1, 0, 1, 9, 9);
        step(0, 1, 0, 0, 0);
        check("t5_rng", 32'(a_range), 32'd0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // counter saturation
        step(1, 0, 1, 1, 2);
        for (int i = 0; i < 9; i++) step(0, 0, 1, i * 20, 255 - i);
        step(0, 1, 0, 0, 0);
        check("t6_acnt", 32'(a_cnt), 32'd7);
        check("t6_bcnt", 32'(b_cnt), 32'd10);
        step(0, 0, 0, 0, 0);

        // random sessions
        for (int s = 0; s < 6; s++) begin
            step(1, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                step(0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            step(0, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            step(0, 0, 0, 0, 0);
        end

        // asynchronous reset mid-session
        step(1, 0, 1, 33, 44);
        step(0, 0, 1, 55, 66);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("arst");
        m_reset();
        go         = 1'b0;
        data_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
